// File: rtl/uart_rx_datapath.sv
// UART receive datapath: two-flop line synchronizer, oversampled start/data/stop
// framing, one-clock ready and frame-error pulses for each completed frame.
module uart_rx_datapath #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    input  logic                 Baud8Tick,
    output logic [DATA_BITS-1:0] RxD_data,
    output logic                 RxD_data_ready,
    output logic                 RxD_frame_err,
    output logic                 Busy
);

    localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [OS_W-1:0]  OS_ZERO      = OS_W'(0);
    localparam logic [OS_W-1:0]  OS_ONE       = OS_W'(1);
    localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO     = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_s;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [OS_W-1:0]      os_cnt_r;
    logic [OS_W-1:0]      os_cnt_nxt_s;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_nxt_s;
    logic                 ready_r;
    logic                 ready_nxt_s;
    logic                 frame_err_r;
    logic                 frame_err_nxt_s;
    logic                 busy_r;

    assign rx_s           = rx_sync_r;
    assign RxD_data       = data_r;
    assign RxD_data_ready = ready_r;
    assign RxD_frame_err  = frame_err_r;
    assign Busy           = busy_r;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= RxD;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Framing state machine: all movement is gated by the oversampling tick
    always_comb begin
        state_nxt_s     = state_r;
        os_cnt_nxt_s    = os_cnt_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        data_nxt_s      = data_r;
        ready_nxt_s     = 1'b0;
        frame_err_nxt_s = 1'b0;
        if (Baud8Tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_s == 1'b0) begin
                        state_nxt_s  = ST_START;
                        os_cnt_nxt_s = OS_ZERO;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (os_cnt_r == OS_HALF_LAST) begin
                        os_cnt_nxt_s = OS_ZERO;
                        if (rx_s == 1'b0) begin
                            state_nxt_s   = ST_DATA;
                            bit_cnt_nxt_s = BIT_ZERO;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        os_cnt_nxt_s = os_cnt_r + OS_ONE;
                    end
                end
                ST_DATA: begin
                    if (os_cnt_r == OS_LAST) begin
                        // LSB arrives first, so new bits enter at the top
                        shift_nxt_s  = {rx_s, shift_r[DATA_BITS-1:1]};
                        os_cnt_nxt_s = OS_ZERO;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_nxt_s = ST_STOP;
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
                        end
                    end else begin
                        os_cnt_nxt_s = os_cnt_r + OS_ONE;
                    end
                end
                ST_STOP: begin
                    if (os_cnt_r == OS_LAST) begin
                        if (rx_s == 1'b1) begin
                            data_nxt_s  = shift_r;
                            ready_nxt_s = 1'b1;
                        end else begin
                            frame_err_nxt_s = 1'b1;
                        end
                        state_nxt_s  = ST_IDLE;
                        os_cnt_nxt_s = OS_ZERO;
                    end else begin
                        os_cnt_nxt_s = os_cnt_r + OS_ONE;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    os_cnt_nxt_s = OS_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            os_cnt_r    <= OS_ZERO;
            bit_cnt_r   <= BIT_ZERO;
            shift_r     <= {DATA_BITS{1'b0}};
            data_r      <= {DATA_BITS{1'b0}};
            ready_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            os_cnt_r    <= os_cnt_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            data_r      <= data_nxt_s;
            ready_r     <= ready_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

endmodule
